// File: rtl/vga_frame_painter_if.sv
// ---------------------------------------------------------------------------
// vga_frame_painter_if
// Pixel-write bus between the frame painter and the VGA adapter.
//   x, y     : target pixel coordinates
//   color    : pixel colour
//   writeEn  : one-cycle write strobe; x/y/color are valid while it is high
// Modports: master (painter drives the bus), slave (adapter consumes it).
// ---------------------------------------------------------------------------
interface vga_frame_painter_if #(
    parameter int XW      = 9,
    parameter int YW      = 8,
    parameter int COLOR_W = 3
);
    logic [XW-1:0]      x;
    logic [YW-1:0]      y;
    logic [COLOR_W-1:0] color;
    logic               writeEn;

    modport master (output x, output y, output color, output writeEn);
    modport slave  (input  x, input  y, input  color, input  writeEn);
endinterface

// File: rtl/vga_frame_painter.sv
// ---------------------------------------------------------------------------
// vga_frame_painter
// On every V_SYNC falling edge paints one frame through the pixel-write bus:
// a full background from an external ROM, an optional NUM_DIGITS decimal
// readout of iValue from external glyph ROMs, then a clipped square cursor.
//
// Ports:
//   clk, iReset           clock, synchronous active-high reset
//   V_SYNC                vertical sync (active low); falling edge = frame start
//   iShowDigits, iValue   digit enable and value, latched at frame start
//   iMouseX, iMouseY      cursor centre, latched at frame start
//   oBgAddr / iBgPixel    background ROM (row-major, 1-cycle read latency)
//   oGlyphAddr / oGlyphDigit / iGlyphPixel  glyph ROM (1-cycle read latency)
//   pix                   pixel-write bus (x, y, color, writeEn)
//   oBusy                 frame in progress
//   oOverrun              one-cycle pulse when a frame start is dropped
//
// Build option: define VGA_GLYPH_TRANSPARENT_EN to suppress writes of black
// (zero) glyph pixels; the glyph phase keeps the same cycle count.
// ---------------------------------------------------------------------------
module vga_frame_painter #(
    parameter int H_RES        = 320,
    parameter int V_RES        = 240,
    parameter int COLOR_W      = 3,
    parameter int VALUE_W      = 12,
    parameter int NUM_DIGITS   = 4,
    parameter int GLYPH_W      = 18,
    parameter int GLYPH_H      = 18,
    parameter int DIGIT_X      = 120,
    parameter int DIGIT_Y      = 155,
    parameter int DIGIT_GAP    = 0,
    parameter int CURSOR_SIZE  = 4,
    parameter int CURSOR_COLOR = 0
) (
    input  logic                                 clk,
    input  logic                                 iReset,
    input  logic                                 V_SYNC,
    input  logic                                 iShowDigits,
    input  logic [VALUE_W-1:0]                   iValue,
    input  logic [$clog2(H_RES)-1:0]             iMouseX,
    input  logic [$clog2(V_RES)-1:0]             iMouseY,
    output logic [$clog2(H_RES*V_RES)-1:0]       oBgAddr,
    input  logic [COLOR_W-1:0]                   iBgPixel,
    output logic [$clog2(GLYPH_W*GLYPH_H)-1:0]   oGlyphAddr,
    output logic [3:0]                           oGlyphDigit,
    input  logic [COLOR_W-1:0]                   iGlyphPixel,
    vga_frame_painter_if.master                  pix,
    output logic                                 oBusy,
    output logic                                 oOverrun
);
    localparam int XW    = $clog2(H_RES);
    localparam int YW    = $clog2(V_RES);
    localparam int BGAW  = $clog2(H_RES * V_RES);
    localparam int GAW   = $clog2(GLYPH_W * GLYPH_H);
    localparam int GCW   = $clog2(GLYPH_W + 1);
    localparam int GRW   = $clog2(GLYPH_H + 1);
    localparam int CSW   = $clog2(CURSOR_SIZE + 1);
    localparam int DIW   = $clog2(NUM_DIGITS + 1);
    localparam int BCD_W = 4 * NUM_DIGITS;
    localparam int BCW   = $clog2(VALUE_W + 1);
    localparam int PITCH = GLYPH_W + DIGIT_GAP;
    localparam logic [63:0] MAX_VAL = 64'(10 ** NUM_DIGITS - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_BG, ST_DIGITS, ST_CURSOR} state_t;
    typedef enum logic [1:0] {SRC_NONE, SRC_BG, SRC_GLYPH, SRC_CURSOR} src_t;

    // Digit i (0 = most significant); saturated values show all nines.
    function automatic logic [3:0] digit_at(input logic [BCD_W-1:0] b, input logic sat,
                                            input logic [DIW-1:0] idx);
        int lsb;
        lsb = (NUM_DIGITS - 1 - int'(idx)) * 4;
        return sat ? 4'd9 : b[lsb +: 4];
    endfunction

    // Index of the first digit to draw: leading zeros are skipped, the
    // least significant digit is always drawn.
    function automatic logic [DIW-1:0] first_digit(input logic [BCD_W-1:0] b, input logic sat);
        logic [DIW-1:0] f;
        f = DIW'(NUM_DIGITS - 1);
        for (int i = NUM_DIGITS - 2; i >= 0; i--) begin
            if (digit_at(b, sat, DIW'(i)) != 4'd0) f = DIW'(i);
        end
        return f;
    endfunction

    // One double-dabble step: add 3 to every digit >= 5, then shift in a bit.
    function automatic logic [BCD_W-1:0] dabble(input logic [BCD_W-1:0] b, input logic bit_in);
        logic [BCD_W-1:0] t;
        t = b;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (t[4*k +: 4] >= 4'd5) t[4*k +: 4] = t[4*k +: 4] + 4'd3;
        end
        return {t[BCD_W-2:0], bit_in};
    endfunction

    state_t             r_state;
    logic               r_vsync_q, r_busy, r_overrun, r_show, r_dig_armed, r_sat;
    logic [XW-1:0]      r_px, r_mx;
    logic [YW-1:0]      r_py, r_my;
    logic [BGAW-1:0]    r_bg_addr;
    logic [GAW-1:0]     r_glyph_addr;
    logic [GCW-1:0]     r_gc;
    logic [GRW-1:0]     r_gr;
    logic [DIW-1:0]     r_dig_idx;
    logic [3:0]         r_glyph_digit;
    logic [15:0]        r_dig_x0;
    logic [CSW-1:0]     r_cc, r_cr;
    logic [VALUE_W-1:0] r_bin;
    logic [BCD_W-1:0]   r_bcd;
    logic [BCW-1:0]     r_bcd_cnt;
    logic [XW-1:0]      r_x;
    logic [YW-1:0]      r_y;
    logic               r_we;
    src_t               r_src;

    logic               w_frame_start, w_start, w_bcd_done;
    logic [DIW-1:0]     w_first;
    logic [15:0]        w_first_x0;
    logic               w_s0_valid, w_s0_we;
    src_t               w_s0_src;
    logic [XW-1:0]      w_s0_x;
    logic [YW-1:0]      w_s0_y;
    int                 w_cur_xi, w_cur_yi;
    logic [COLOR_W-1:0] w_color;
    logic               w_we;

    assign w_frame_start = r_vsync_q & ~V_SYNC;
    assign w_start       = w_frame_start & (r_state == ST_IDLE);
    assign w_bcd_done    = (r_bcd_cnt == BCW'(0));
    assign w_first       = first_digit(r_bcd, r_sat);
    assign w_first_x0    = 16'(DIGIT_X + int'(w_first) * PITCH);

    assign oBgAddr     = r_bg_addr;
    assign oGlyphAddr  = r_glyph_addr;
    assign oGlyphDigit = r_glyph_digit;
    assign oBusy       = r_busy;
    assign oOverrun    = r_overrun;
    assign pix.x       = r_x;
    assign pix.y       = r_y;
    assign pix.color   = w_color;
    assign pix.writeEn = w_we;

    // Sequential binary-to-BCD conversion, started at frame start.
    always_ff @(posedge clk) begin
        if (iReset) begin
            r_bin <= '0; r_bcd <= '0; r_bcd_cnt <= '0; r_sat <= 1'b0;
        end else if (w_start) begin
            r_bin     <= iValue;
            r_bcd     <= '0;
            r_bcd_cnt <= BCW'(VALUE_W);
            r_sat     <= (64'(iValue) > MAX_VAL);
        end else if (!w_bcd_done) begin
            r_bcd     <= dabble(r_bcd, r_bin[VALUE_W-1]);
            r_bin     <= r_bin << 1;
            r_bcd_cnt <= r_bcd_cnt - BCW'(1);
        end
    end

    // Frame FSM and stage-0 counters/addresses.
    always_ff @(posedge clk) begin
        if (iReset) begin
            r_state <= ST_IDLE; r_vsync_q <= 1'b1; r_busy <= 1'b0; r_overrun <= 1'b0;
            r_show <= 1'b0; r_mx <= '0; r_my <= '0; r_px <= '0; r_py <= '0;
            r_bg_addr <= '0; r_glyph_addr <= '0; r_gc <= '0; r_gr <= '0;
            r_dig_idx <= '0; r_glyph_digit <= 4'd0; r_dig_x0 <= 16'd0; r_dig_armed <= 1'b0;
            r_cc <= '0; r_cr <= '0;
        end else begin
            r_vsync_q <= V_SYNC;
            r_overrun <= w_frame_start & (r_state != ST_IDLE);
            r_busy    <= (r_state != ST_IDLE) | w_start;
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_show <= iShowDigits; r_mx <= iMouseX; r_my <= iMouseY;
                        r_px <= '0; r_py <= '0; r_bg_addr <= '0;
                        r_state <= ST_BG;
                    end
                end
                ST_BG: begin
                    r_bg_addr <= r_bg_addr + BGAW'(1);
                    if (r_px == XW'(H_RES - 1)) begin
                        r_px <= '0;
                        if (r_py == YW'(V_RES - 1)) begin
                            r_py <= '0;
                            r_gc <= '0; r_gr <= '0; r_glyph_addr <= '0;
                            r_cc <= '0; r_cr <= '0;
                            // Digit selection is only trusted once conversion is done.
                            r_dig_armed   <= w_bcd_done;
                            r_dig_idx     <= w_first;
                            r_glyph_digit <= digit_at(r_bcd, r_sat, w_first);
                            r_dig_x0      <= w_first_x0;
                            r_state       <= r_show ? ST_DIGITS : ST_CURSOR;
                        end else begin
                            r_py <= r_py + YW'(1);
                        end
                    end else begin
                        r_px <= r_px + XW'(1);
                    end
                end
                ST_DIGITS: begin
                    if (!r_dig_armed) begin
                        if (w_bcd_done) begin
                            r_dig_armed   <= 1'b1;
                            r_dig_idx     <= w_first;
                            r_glyph_digit <= digit_at(r_bcd, r_sat, w_first);
                            r_dig_x0      <= w_first_x0;
                        end
                    end else begin
                        r_glyph_addr <= r_glyph_addr + GAW'(1);
                        if (r_gc == GCW'(GLYPH_W - 1)) begin
                            r_gc <= '0;
                            if (r_gr == GRW'(GLYPH_H - 1)) begin
                                r_gr <= '0;
                                r_glyph_addr <= '0;
                                if (r_dig_idx == DIW'(NUM_DIGITS - 1)) begin
                                    r_dig_armed <= 1'b0;
                                    r_state     <= ST_CURSOR;
                                end else begin
                                    r_dig_idx     <= r_dig_idx + DIW'(1);
                                    r_glyph_digit <= digit_at(r_bcd, r_sat, r_dig_idx + DIW'(1));
                                    r_dig_x0      <= r_dig_x0 + 16'(PITCH);
                                end
                            end else begin
                                r_gr <= r_gr + GRW'(1);
                            end
                        end else begin
                            r_gc <= r_gc + GCW'(1);
                        end
                    end
                end
                ST_CURSOR: begin
                    if (r_cc == CSW'(CURSOR_SIZE - 1)) begin
                        r_cc <= '0;
                        if (r_cr == CSW'(CURSOR_SIZE - 1)) begin
                            r_cr    <= '0;
                            r_state <= ST_IDLE;
                        end else begin
                            r_cr <= r_cr + CSW'(1);
                        end
                    end else begin
                        r_cc <= r_cc + CSW'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Stage 0: target pixel, source and write qualifier for the address issued now.
    always_comb begin
        w_s0_valid = 1'b0;
        w_s0_we    = 1'b0;
        w_s0_src   = SRC_NONE;
        w_s0_x     = '0;
        w_s0_y     = '0;
        // Cursor pixel in signed screen space so off-screen parts can be clipped.
        w_cur_xi   = int'(r_mx) - CURSOR_SIZE / 2 + int'(r_cc);
        w_cur_yi   = int'(r_my) - CURSOR_SIZE / 2 + int'(r_cr);
        case (r_state)
            ST_BG: begin
                w_s0_valid = 1'b1; w_s0_we = 1'b1; w_s0_src = SRC_BG;
                w_s0_x = r_px; w_s0_y = r_py;
            end
            ST_DIGITS: begin
                if (r_dig_armed) begin
                    w_s0_valid = 1'b1; w_s0_we = 1'b1; w_s0_src = SRC_GLYPH;
                    w_s0_x = XW'(int'(r_dig_x0) + int'(r_gc));
                    w_s0_y = YW'(DIGIT_Y + int'(r_gr));
                end else begin
                    w_s0_valid = 1'b0;
                end
            end
            ST_CURSOR: begin
                w_s0_valid = 1'b1; w_s0_src = SRC_CURSOR;
                w_s0_we = (w_cur_xi >= 0) && (w_cur_xi < H_RES) &&
                          (w_cur_yi >= 0) && (w_cur_yi < V_RES);
                w_s0_x = w_cur_xi[XW-1:0];
                w_s0_y = w_cur_yi[YW-1:0];
            end
            default: w_s0_valid = 1'b0;
        endcase
    end

    // Stage 1: register x/y/strobe so they line up with the ROM read data.
    always_ff @(posedge clk) begin
        if (iReset) begin
            r_x <= '0; r_y <= '0; r_we <= 1'b0; r_src <= SRC_NONE;
        end else begin
            r_x   <= w_s0_x;
            r_y   <= w_s0_y;
            r_we  <= w_s0_valid & w_s0_we;
            r_src <= w_s0_valid ? w_s0_src : SRC_NONE;
        end
    end

    // Colour source mux and final write strobe for stage 1.
    always_comb begin
        case (r_src)
            SRC_BG:     w_color = iBgPixel;
            SRC_GLYPH:  w_color = iGlyphPixel;
            SRC_CURSOR: w_color = COLOR_W'(CURSOR_COLOR);
            default:    w_color = '0;
        endcase
`ifdef VGA_GLYPH_TRANSPARENT_EN
        w_we = r_we & ~((r_src == SRC_GLYPH) && (iGlyphPixel == '0));
`else
        w_we = r_we;
`endif
    end
endmodule
